// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared sizes, state encoding and matrix types for the systolic sequencer
package systolic_pkg;

  localparam int N           = 4;
  localparam int W           = 8;
  localparam int W_C         = 8;
  localparam int FEED_CYCLES = 3 * N - 2;
  localparam int CNT_W       = $clog2(FEED_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef logic [N-1:0][N-1:0][W-1:0]   matrix_t;
  typedef logic [N-1:0][N-1:0][W_C-1:0] result_t;

endpackage

// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - times one 4x4 systolic multiply: operand capture, load/clear/feed, result hold
module systolic_sequencer
  import systolic_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N*N*W-1:0]       i_a,
  input  logic [N*N*W-1:0]       i_b,
  output logic [N*N*W-1:0]       o_a,
  output logic [N*N*W-1:0]       o_b,
  output logic                   o_load,
  output logic                   o_clear,
  output logic                   o_feedEn,
  input  logic [N*N*W_C-1:0]     i_c,
  output logic [N*N*W_C-1:0]     o_c,
  output logic                   o_validResult,
  input  logic                   i_resultReady,
  output logic                   o_busy
);

  // The last shift needs the skew of row N-1 plus column N-1 to drain into PE(N-1,N-1).
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FEED_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  feed_cnt_q, feed_cnt_d;
  matrix_t           a_q, a_d;
  matrix_t           b_q, b_d;
  result_t           c_q, c_d;

  logic load_q, load_d;
  logic clear_q, clear_d;
  logic feed_en_q, feed_en_d;
  logic valid_result_q, valid_result_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;

  // Next-state, counter and operand/result register updates; controls decode from the next state so they come out of flops.
  always_comb begin
    state_d    = state_q;
    feed_cnt_d = feed_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        feed_cnt_d = '0;
        state_d    = FEED;
      end
      FEED: begin
        if (feed_cnt_q == LAST_CNT) begin
          state_d = DRAIN;
        end else begin
          feed_cnt_d = feed_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        c_d     = i_c;
        state_d = DONE;
      end
      DONE: begin
        if (i_resultReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    load_d         = (state_d == LOAD);
    clear_d        = (state_d == LOAD);
    feed_en_d      = (state_d == FEED);
    valid_result_d = (state_d == DONE);
    ready_d        = (state_d == IDLE);
    busy_d         = (state_d != IDLE);
  end

  // FSM state, counter, datapath registers and registered control outputs; reset drops every pulse at once.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q        <= IDLE;
      feed_cnt_q     <= '0;
      a_q            <= '0;
      b_q            <= '0;
      c_q            <= '0;
      load_q         <= 1'b0;
      clear_q        <= 1'b0;
      feed_en_q      <= 1'b0;
      valid_result_q <= 1'b0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      feed_cnt_q     <= feed_cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      c_q            <= c_d;
      load_q         <= load_d;
      clear_q        <= clear_d;
      feed_en_q      <= feed_en_d;
      valid_result_q <= valid_result_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
    end
  end

  assign o_a           = a_q;
  assign o_b           = b_q;
  assign o_c           = c_q;
  assign o_load        = load_q;
  assign o_clear       = clear_q;
  assign o_feedEn      = feed_en_q;
  assign o_validResult = valid_result_q;
  assign o_ready       = ready_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - directed bench for systolic_sequencer with a behavioural 4x4 array
module tb_systolic_sequencer;

  logic clk;
  logic i_arst;
  logic i_valid;
  logic o_ready;
  logic [3:0][3:0][7:0] a_in, b_in;
  logic [3:0][3:0][7:0] o_a, o_b;
  logic o_load, o_clear, o_feedEn;
  logic [3:0][3:0][7:0] dut_ic;
  logic [3:0][3:0][7:0] o_c;
  logic o_validResult;
  logic i_resultReady;
  logic o_busy;

  logic use_array;
  logic [3:0][3:0][7:0] stub_c;

  logic [3:0][3:0][7:0] ld_a, ld_b, acc, ap, bp;
  int shift_k;

  int checks;
  int errors;

  systolic_sequencer dut (
    .i_clk         (clk),
    .i_arst        (i_arst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_a           (a_in),
    .i_b           (b_in),
    .o_a           (o_a),
    .o_b           (o_b),
    .o_load        (o_load),
    .o_clear       (o_clear),
    .o_feedEn      (o_feedEn),
    .i_c           (dut_ic),
    .o_c           (o_c),
    .o_validResult (o_validResult),
    .i_resultReady (i_resultReady),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_ic = use_array ? acc : stub_c;

  function automatic logic [7:0] feed_a(int i, int k);
    int t;
    t = k - i;
    if (t >= 0 && t < 4) return ld_a[i][t];
    return 8'h00;
  endfunction

  function automatic logic [7:0] feed_b(int j, int k);
    int t;
    t = k - j;
    if (t >= 0 && t < 4) return ld_b[t][j];
    return 8'h00;
  endfunction

  // Behavioural output-stationary array: skewed feeders, pass registers, accumulators.
  always @(posedge clk) begin
    logic [7:0] av, bv, prod;
    if (o_clear) begin
      acc <= '0;
      ap  <= '0;
      bp  <= '0;
    end
    if (o_load) begin
      ld_a    <= o_a;
      ld_b    <= o_b;
      shift_k <= 0;
    end else if (o_feedEn) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          av = (j == 0) ? feed_a(i, shift_k) : ap[i][j-1];
          bv = (i == 0) ? feed_b(j, shift_k) : bp[i-1][j];
          prod = 8'(av * bv);
          acc[i][j] <= acc[i][j] + prod;
          ap[i][j]  <= av;
          bp[i][j]  <= bv;
        end
      end
      shift_k <= shift_k + 1;
    end
  end

  function automatic logic [5:0] ctrl_now();
    return {o_ready, o_busy, o_load, o_clear, o_feedEn, o_validResult};
  endfunction

  // Expected {ready,busy,load,clear,feedEn,validResult} for cycle c after a handshake at cycle 0, result taken at 13.
  function automatic logic [5:0] exp_ctrl(int c);
    if (c == 0 || c >= 14) return 6'b100000;
    if (c == 1) return 6'b011100;
    if (c >= 2 && c <= 11) return 6'b010010;
    if (c == 12) return 6'b010000;
    return 6'b010001;
  endfunction

  function automatic logic [3:0][3:0][7:0] pattern(int base);
    logic [3:0][3:0][7:0] m;
    for (int idx = 0; idx < 16; idx++) m[idx/4][idx%4] = 8'(base + idx);
    return m;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_arst = 1'b1;
    step();
    step();
    checks++;
    if (ctrl_now() !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl actual=%b required=%b", ctrl_now(), 6'b100000);
    end
    i_arst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if (ctrl_now() !== 6'b100000 || o_c !== '0 || o_a !== '0 || o_b !== '0) begin
        errors++;
        $display("FAIL idle_after_reset cycle=%0d ctrl=%b required=100000 o_c=%h o_a=%h o_b=%h required zero",
                 n, ctrl_now(), o_c, o_a, o_b);
      end
    end
  endtask

  task automatic test_single_op();
    logic [3:0][3:0][7:0] expc;
    expc = {16{8'h5A}};
    use_array = 1'b0;
    stub_c = '0;
    i_resultReady = 1'b1;
    a_in = pattern(8'h10);
    b_in = pattern(8'h40);
    i_valid = 1'b1;
    checks++;
    if (ctrl_now() !== exp_ctrl(0)) begin
      errors++;
      $display("FAIL single_ctrl cycle=0 actual=%b required=%b", ctrl_now(), exp_ctrl(0));
    end
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) i_valid = 1'b0;
      stub_c = (c == 12) ? expc : '0;
      checks++;
      if (ctrl_now() !== exp_ctrl(c)) begin
        errors++;
        $display("FAIL single_ctrl cycle=%0d actual=%b required=%b", c, ctrl_now(), exp_ctrl(c));
      end
      if (c >= 13) begin
        checks++;
        if (o_c !== expc) begin
          errors++;
          $display("FAIL single_result cycle=%0d actual=%h required=%h", c, o_c, expc);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0][3:0][7:0] pa, expc;
    pa   = pattern(8'h20);
    expc = pattern(8'hC0);
    use_array = 1'b0;
    stub_c = '0;
    i_resultReady = 1'b0;
    a_in = pa;
    b_in = pattern(8'h60);
    i_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) i_valid = 1'b0;
      stub_c = (c == 12) ? expc : '0;
    end
    for (int c = 13; c < 43; c++) begin
      step();
      stub_c = {$urandom, $urandom, $urandom, $urandom};
      i_valid = 1'b1;
      a_in = ~pa;
      checks++;
      if (ctrl_now() !== 6'b010001 || o_c !== expc || o_a !== pa) begin
        errors++;
        $display("FAIL backpressure_hold cycle=%0d ctrl=%b required=010001 o_c=%h required=%h o_a=%h required=%h",
                 c, ctrl_now(), o_c, expc, o_a, pa);
      end
    end
    step();
    i_resultReady = 1'b1;
    i_valid = 1'b1;
    step();
    checks++;
    if (ctrl_now() !== 6'b100000 || o_a !== pa) begin
      errors++;
      $display("FAIL backpressure_release ctrl=%b required=100000 o_a=%h required=%h", ctrl_now(), o_a, pa);
    end
    i_valid = 1'b0;
    step();
    checks++;
    if (ctrl_now() !== 6'b100000 || o_a !== pa || o_c !== expc) begin
      errors++;
      $display("FAIL backpressure_after ctrl=%b required=100000 o_a=%h required=%h o_c=%h required=%h",
               ctrl_now(), o_a, pa, o_c, expc);
    end
  endtask

  task automatic test_back_to_back();
    use_array = 1'b0;
    stub_c = '0;
    i_resultReady = 1'b1;
    a_in = pattern(0);
    b_in = pattern(8'h80);
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= 14; c++) begin
        step();
        checks++;
        if (ctrl_now() !== exp_ctrl(c)) begin
          errors++;
          $display("FAIL b2b_ctrl op=%0d cycle=%0d actual=%b required=%b", k, c, ctrl_now(), exp_ctrl(c));
        end
        if (c == 1) begin
          checks++;
          if (o_a !== pattern(k * 16) || o_b !== pattern(8'h80 + k * 16)) begin
            errors++;
            $display("FAIL b2b_operands op=%0d o_a=%h required=%h o_b=%h required=%h",
                     k, o_a, pattern(k * 16), o_b, pattern(8'h80 + k * 16));
          end
        end
        if (c == 14) begin
          a_in = pattern((k + 1) * 16);
          b_in = pattern(8'h80 + (k + 1) * 16);
          if (k == 2) i_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_full_datapath();
    logic [3:0][3:0][7:0] ident, bm;
    ident = '0;
    for (int i = 0; i < 4; i++) ident[i][i] = 8'd1;
    bm = pattern(1);
    use_array = 1'b1;
    i_resultReady = 1'b1;
    a_in = ident;
    b_in = bm;
    i_valid = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1) i_valid = 1'b0;
    end
    checks++;
    if (o_validResult !== 1'b1 || o_c !== bm) begin
      errors++;
      $display("FAIL full_datapath valid=%b o_c=%h required=%h", o_validResult, o_c, bm);
    end
    step();
    use_array = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_resultReady = 1'b1;
    a_in = pattern(8'h33);
    b_in = pattern(8'h77);
    i_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) i_valid = 1'b0;
    end
    checks++;
    if (ctrl_now() !== exp_ctrl(8)) begin
      errors++;
      $display("FAIL reset_mid_pre actual=%b required=%b", ctrl_now(), exp_ctrl(8));
    end
    i_arst = 1'b1;
    #1;
    checks++;
    if (ctrl_now() !== 6'b100000) begin
      errors++;
      $display("FAIL reset_mid_immediate actual=%b required=100000", ctrl_now());
    end
    step();
    i_arst = 1'b0;
    checks++;
    if (ctrl_now() !== 6'b100000 || o_a !== '0) begin
      errors++;
      $display("FAIL reset_mid_state ctrl=%b required=100000 o_a=%h required=0", ctrl_now(), o_a);
    end
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if (ctrl_now() !== 6'b100000) begin
        errors++;
        $display("FAIL reset_mid_quiet cycle=%0d actual=%b required=100000", n, ctrl_now());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_arst = 1'b1;
    i_valid = 1'b0;
    i_resultReady = 1'b0;
    a_in = '0;
    b_in = '0;
    use_array = 1'b0;
    stub_c = '0;
    test_reset();
    test_single_op();
    test_backpressure();
    test_back_to_back();
    test_full_datapath();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Controller that sequences one 4x4 systolic-array multiply at a time. It accepts an operand pair (A, B) over a valid/ready handshake and registers the operands. It then drives the load, accumulator-clear and feed-enable controls of the row/column feeders and PE grid for the exact number of compute cycles. Finally it captures the array's result matrix and holds it until the consumer accepts it. It sits between the upstream operand source and the systolic datapath and is the only block that times the array.

## Interface
- N, 4, matrix dimension (only 4 is verified)
- W, 8, operand element width
- W_C, 8, result element width as produced by the array
- i_clk  in  1  clock, all state on rising edge
- i_arst  in  1  reset, asynchronous, active-high
- i_valid  in  1  operand pair offered
- o_ready  out  1  sequencer can accept an operand pair
- i_a  in  N*N*W  matrix A, [row][col][bit]
- i_b  in  N*N*W  matrix B, [row][col][bit]
- o_a  out  N*N*W  registered A to the row feeders
- o_b  out  N*N*W  registered B to the column feeders
- o_load  out  1  one-cycle pulse: feeders load skewed rows/cols from o_a/o_b
- o_clear  out  1  one-cycle pulse: PE accumulators and PE pass registers clear
- o_feedEn  out  1  feeders shift one element and PEs accumulate
- i_c  in  N*N*W_C  result matrix from the PE grid
- o_c  out  N*N*W_C  captured result, stable while o_validResult
- o_validResult  out  1  result available
- i_resultReady  in  1  consumer accepts result
- o_busy  out  1  state != IDLE

## Operation
- States are IDLE, LOAD, FEED, DRAIN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid: capture i_a/i_b into o_a/o_b and go to LOAD.
- LOAD (1 cycle):
  - o_load=1, o_clear=1.
  - Load feedCnt=0.
  - Then go to FEED.
- FEED (FEED_CYCLES = 3N-2 = 10 cycles):
  - o_feedEn=1, feedCnt increments 0..9.
  - When feedCnt == FEED_CYCLES-1, go to DRAIN.
  - The feeders supply zeros after 2N-1 shifts; the remaining cycles flush the skew to PE(N-1,N-1).
- DRAIN (1 cycle):
  - The last accumulate has settled into i_c.
  - At the end of the cycle, o_c <= i_c. Go to DONE.
- DONE:
  - o_validResult=1.
  - On i_resultReady, go to IDLE.
  - o_c stays held after leaving DONE until the next DRAIN capture.
- o_ready is asserted only in IDLE. i_valid outside IDLE is ignored, and no operand register changes.
- Operand and result registers update only at the states named above. i_a/i_b changing mid-operation has no effect.
- feedCnt width is clog2(FEED_CYCLES). It never wraps; it is reloaded in LOAD.
- All control outputs (o_load, o_clear, o_feedEn, o_validResult, o_ready, o_busy) are decoded from registered state only, with no combinational input-to-output path.

## Timing
- Reset values:
  - State = IDLE, feedCnt=0, o_a/o_b/o_c = 0.
  - o_ready=1, o_busy=0, o_load=o_clear=o_feedEn=o_validResult=0.
- Cycle numbering, with cycle 0 = handshake cycle (i_valid & o_ready):
  - Cycle 1: LOAD.
  - Cycles 2..11: FEED.
  - Cycle 12: DRAIN.
  - Cycle 13 onward: DONE.
- Latency from accept to o_validResult is 13 cycles. Throughput is one multiply per 14 cycles minimum, when i_resultReady is held high.
- DONE with i_resultReady=1 at cycle k:
  - IDLE at k+1.
  - A new accept is possible at k+1.
  - A simultaneous i_valid in DONE is not accepted.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - No partial o_validResult.
  - Datapath control pulses drop in the same cycle that reset is asserted.

## Structure
- Package systolic_pkg holds:
  - N, W, W_C.
  - FEED_CYCLES = 3*N-2.
  - State enum typedef state_t {IDLE, LOAD, FEED, DRAIN, DONE}.
  - Typedefs matrix_t (logic [N-1:0][N-1:0][W-1:0]) and result_t.
- Single flat module; no sub-module is warranted. The FSM, counter and operand/result registers are each small.

## Test plan
- Reset then idle:
  - o_ready=1, o_busy=0, all pulses 0, o_c=0 for 20 cycles with i_valid=0.
- Single op, with the array stub driving i_c=all 8'h5A only in cycle 12, i_resultReady=1:
  - o_load/o_clear high only in cycle 1.
  - o_feedEn high exactly cycles 2..11.
  - o_validResult high in cycle 13 only.
  - o_c = all 8'h5A.
- Backpressure, with i_resultReady=0 for 30 cycles:
  - o_validResult stays 1 and o_c stays stable.
  - o_ready=0 and a second i_valid is ignored, with o_a unchanged.
  - Releasing i_resultReady leads to IDLE next cycle.
- Back-to-back, with i_valid held high and A/B incrementing per accept:
  - Accepts occur every 14 cycles.
  - o_a/o_b match the operands offered at each accept.
- Reset at cycle 6 of FEED:
  - Next cycle o_feedEn=0, o_busy=0, o_ready=1.
  - No o_validResult follows.
- Full datapath, with A=identity and B=[[1..4],[5..8],[9..12],[13..16]] through the real array:
  - o_c = B at cycle 13.
